// File: rtl/commit_trace_fifo_pkg.sv
// Shared definitions for the commit trace path: record kind codes, event-mask
// bit positions, the captured bundle layout and the record selector.
package commit_trace_fifo_pkg;

  localparam logic [2:0] TRACE_KIND_GPR = 3'd0;
  localparam logic [2:0] TRACE_KIND_CR  = 3'd1;
  localparam logic [2:0] TRACE_KIND_MSR = 3'd2;
  localparam logic [2:0] TRACE_KIND_SPR = 3'd3;
  localparam logic [2:0] TRACE_KIND_DM  = 3'd4;

  // Event-mask bit positions; lower index is emitted first (program order).
  localparam int unsigned NEV     = 6;
  localparam int unsigned EV_GPR  = 0;
  localparam int unsigned EV_CR   = 1;
  localparam int unsigned EV_MSR  = 2;
  localparam int unsigned EV_SPR0 = 3;
  localparam int unsigned EV_SPR1 = 4;
  localparam int unsigned EV_DM   = 5;

  typedef struct packed {
    logic [NEV-1:0] mask;
    logic [31:0]    instr_w;
    logic [31:0]    instr_m;
    logic [4:0]     gpr_waddr;
    logic [31:0]    gpr_wd;
    logic [31:0]    cr_wd;
    logic [31:0]    msr_wd;
    logic [9:0]     spr_waddr0;
    logic [31:0]    spr_wd0;
    logic [9:0]     spr_waddr1;
    logic [31:0]    spr_wd1;
    logic [31:0]    dm_addr;
    logic [31:0]    dm_wd;
  } bundle_t;

  localparam int unsigned BUNDLE_W = $bits(bundle_t);

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] tag;
    logic [31:0] instr;
    logic [31:0] data;
  } rec_t;

  // Build the record for the highest-priority event still set in m.
  function automatic rec_t rec_sel(input bundle_t b, input logic [NEV-1:0] m);
    rec_t r;
    r = '0;
    if (m[EV_GPR])
      r = '{TRACE_KIND_GPR, {27'd0, b.gpr_waddr}, b.instr_w, b.gpr_wd};
    else if (m[EV_CR])
      r = '{TRACE_KIND_CR, 32'd0, b.instr_w, b.cr_wd};
    else if (m[EV_MSR])
      r = '{TRACE_KIND_MSR, 32'd0, b.instr_w, b.msr_wd};
    else if (m[EV_SPR0])
      r = '{TRACE_KIND_SPR, {22'd0, b.spr_waddr0}, b.instr_w, b.spr_wd0};
    else if (m[EV_SPR1])
      r = '{TRACE_KIND_SPR, {22'd0, b.spr_waddr1}, b.instr_w, b.spr_wd1};
    else if (m[EV_DM])
      r = '{TRACE_KIND_DM, {b.dm_addr[31:2], 2'b00}, b.instr_m, b.dm_wd};
    return r;
  endfunction

endpackage

// File: rtl/commit_trace_fifo_fifo.sv
// trace_bundle_fifo: synchronous bundle FIFO with async active-low reset.
// Exposes the head entry and the entry behind it so the serializer can
// switch bundles without a bubble.
module trace_bundle_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [W-1:0]             head_nxt,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic          push_ok, pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign rd_nxt   = rd_ptr + AW'(1);
  assign head     = mem[rd_ptr];
  assign head_nxt = mem[rd_nxt];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_nxt;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; a push into a full FIFO only happens alongside a pop,
  // so overwriting the departing head slot is safe.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: captures per-cycle architectural write events as one
// bundle, queues bundles, and serialises them one record per handshake.
// Optional macro COMMIT_TRACE_STALL_EN adds the registered core_stall output.
module commit_trace_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_w,
  input  logic [31:0]       instr_m,
  input  logic              gpr_wr,
  input  logic [4:0]        gpr_waddr,
  input  logic [31:0]       gpr_wd,
  input  logic              cr_wr,
  input  logic [31:0]       cr_wd,
  input  logic              msr_wr,
  input  logic [31:0]       msr_wd,
  input  logic              spr_wr0,
  input  logic [9:0]        spr_waddr0,
  input  logic [31:0]       spr_wd0,
  input  logic              spr_wr1,
  input  logic [9:0]        spr_waddr1,
  input  logic [31:0]       spr_wd1,
  input  logic              dm_wr,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_kind,
  output logic [31:0]       out_tag,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_data,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              overflow
`ifdef COMMIT_TRACE_STALL_EN
  ,
  output logic              core_stall
`endif
);
  import commit_trace_fifo_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  bundle_t             in_b, head_b, head2_b, sel_b;
  logic [BUNDLE_W-1:0] head_raw, head2_raw;
  logic [CW-1:0]       count;
  logic                fifo_full, fifo_empty;
  logic [NEV-1:0]      wmask, m_after, m_nx;
  logic                xfer, pop, push_req, drop, have_old;
  rec_t                rec;

  assign head_b  = head_raw;
  assign head2_b = head2_raw;

  trace_bundle_fifo #(
    .W     (BUNDLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_req),
    .pop      (pop),
    .din      (in_b),
    .head     (head_raw),
    .head_nxt (head2_raw),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Assemble this cycle's write events into a bundle.
  always_comb begin
    in_b            = '0;
    in_b.mask       = {dm_wr, spr_wr1, spr_wr0, msr_wr, cr_wr, gpr_wr};
    in_b.instr_w    = instr_w;
    in_b.instr_m    = instr_m;
    in_b.gpr_waddr  = gpr_waddr;
    in_b.gpr_wd     = gpr_wd;
    in_b.cr_wd      = cr_wd;
    in_b.msr_wd     = msr_wd;
    in_b.spr_waddr0 = spr_waddr0;
    in_b.spr_wd0    = spr_wd0;
    in_b.spr_waddr1 = spr_waddr1;
    in_b.spr_wd1    = spr_wd1;
    in_b.dm_addr    = dm_addr;
    in_b.dm_wd      = dm_wd;
  end

  // Serializer next state. The in-service bundle stays at the FIFO head
  // until its last record is accepted; the next record is picked from the
  // surviving head, the entry behind it, or the incoming bundle (bypass when
  // the queue drains this cycle), so output registers update with no bubble.
  always_comb begin
    push_req = |in_b.mask;
    xfer     = out_valid && out_ready;
    m_after  = xfer ? (wmask & (wmask - NEV'(1))) : wmask;
    pop      = xfer && (m_after == '0);
    drop     = push_req && fifo_full && !pop;
    have_old = pop ? (count > CW'(1)) : !fifo_empty;
    sel_b    = head_b;
    m_nx     = '0;
    if (m_after != '0) begin
      m_nx  = m_after;
      sel_b = head_b;
    end else if (have_old) begin
      sel_b = pop ? head2_b : head_b;
      m_nx  = sel_b.mask;
    end else if (push_req && !drop) begin
      sel_b = in_b;
      m_nx  = in_b.mask;
    end
    rec = rec_sel(sel_b, m_nx);
  end

  // Output registers: hold while stalled, hold last record when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wmask     <= '0;
      out_valid <= 1'b0;
      out_kind  <= '0;
      out_tag   <= '0;
      out_instr <= '0;
      out_data  <= '0;
    end else begin
      wmask     <= m_nx;
      out_valid <= (m_nx != '0);
      if (m_nx != '0) begin
        out_kind  <= rec.kind;
        out_tag   <= rec.tag;
        out_instr <= rec.instr;
        out_data  <= rec.data;
      end
    end
  end

  // Saturating drop counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

`ifdef COMMIT_TRACE_STALL_EN
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - 2);

  // Registered back-pressure request to the core near full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) core_stall <= 1'b0;
    else        core_stall <= (count >= STALL_TH);
  end
`endif

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed self-checking bench for commit_trace_fifo (DEPTH=8, DROP_W=16).
module tb_commit_trace_fifo;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_w, instr_m;
  logic        gpr_wr;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wd;
  logic        cr_wr, msr_wr;
  logic [31:0] cr_wd, msr_wd;
  logic        spr_wr0, spr_wr1;
  logic [9:0]  spr_waddr0, spr_waddr1;
  logic [31:0] spr_wd0, spr_wd1;
  logic        dm_wr;
  logic [31:0] dm_addr, dm_wd;
  logic        out_valid, out_ready;
  logic [2:0]  out_kind;
  logic [31:0] out_tag, out_instr, out_data;
  logic [15:0] drop_cnt;
  logic        overflow;
`ifdef COMMIT_TRACE_STALL_EN
  logic        core_stall;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  commit_trace_fifo #(.DEPTH(8), .DROP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_w(instr_w), .instr_m(instr_m),
    .gpr_wr(gpr_wr), .gpr_waddr(gpr_waddr), .gpr_wd(gpr_wd),
    .cr_wr(cr_wr), .cr_wd(cr_wd), .msr_wr(msr_wr), .msr_wd(msr_wd),
    .spr_wr0(spr_wr0), .spr_waddr0(spr_waddr0), .spr_wd0(spr_wd0),
    .spr_wr1(spr_wr1), .spr_waddr1(spr_waddr1), .spr_wd1(spr_wd1),
    .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wd(dm_wd),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_tag(out_tag), .out_instr(out_instr), .out_data(out_data),
    .drop_cnt(drop_cnt), .overflow(overflow)
`ifdef COMMIT_TRACE_STALL_EN
    , .core_stall(core_stall)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    gpr_wr = 0; cr_wr = 0; msr_wr = 0; spr_wr0 = 0; spr_wr1 = 0; dm_wr = 0;
  endtask

  task automatic push_gpr(input int idx, input logic [31:0] d, input logic [31:0] ins);
    gpr_wr = 1; gpr_waddr = 5'(idx); gpr_wd = d; instr_w = ins;
  endtask

  task automatic test_reset();
    rst_n = 0; out_ready = 0; clear_inputs();
    instr_w = '0; instr_m = '0; gpr_waddr = '0; gpr_wd = '0; cr_wd = '0; msr_wd = '0;
    spr_waddr0 = '0; spr_waddr1 = '0; spr_wd0 = '0; spr_wd1 = '0; dm_addr = '0; dm_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if ({out_kind, out_tag, out_instr, out_data} !== 99'd0) begin failures++; $display("FAIL reset_outs got=%0h/%0h/%0h/%0h exp=0", out_kind, out_tag, out_instr, out_data); end
    checks++; if ({drop_cnt, overflow} !== 17'd0) begin failures++; $display("FAIL reset_drop got=%0d/%b exp=0/0", drop_cnt, overflow); end
    #2 rst_n = 1;
    step();
  endtask

  task automatic test_single_gpr();
    out_ready = 1;
    push_gpr(3, 32'h0000_0010, 32'h3860_0010);
    step();
    clear_inputs();
    checks++; if ({out_valid, out_kind, out_tag, out_data, out_instr} !== {1'b1, 3'd0, 32'd3, 32'h10, 32'h3860_0010})
      begin failures++; $display("FAIL gpr_rec got=%b/%0d/%0h/%0h/%0h exp=1/0/3/10/38600010", out_valid, out_kind, out_tag, out_data, out_instr); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gpr_done got=%b exp=0", out_valid); end
    checks++; if (out_tag !== 32'd3) begin failures++; $display("FAIL gpr_hold got=%0h exp=3", out_tag); end
  endtask

  task automatic test_multi_event();
    out_ready = 1;
    push_gpr(5, 32'h0000_0055, 32'h7C00_0123);
    cr_wr = 1; cr_wd = 32'h2000_0000;
    dm_wr = 1; dm_addr = 32'h0000_3006; dm_wd = 32'hDEAD_BEEF; instr_m = 32'h9000_0004;
    step();
    clear_inputs();
    checks++; if ({out_valid, out_kind, out_tag, out_data, out_instr} !== {1'b1, 3'd0, 32'd5, 32'h55, 32'h7C00_0123})
      begin failures++; $display("FAIL multi_gpr got=%b/%0d/%0h/%0h/%0h exp=1/0/5/55/7c000123", out_valid, out_kind, out_tag, out_data, out_instr); end
    step();
    checks++; if ({out_valid, out_kind, out_tag, out_data, out_instr} !== {1'b1, 3'd1, 32'd0, 32'h2000_0000, 32'h7C00_0123})
      begin failures++; $display("FAIL multi_cr got=%b/%0d/%0h/%0h/%0h exp=1/1/0/20000000/7c000123", out_valid, out_kind, out_tag, out_data, out_instr); end
    step();
    checks++; if ({out_valid, out_kind, out_tag, out_data, out_instr} !== {1'b1, 3'd4, 32'h3004, 32'hDEAD_BEEF, 32'h9000_0004})
      begin failures++; $display("FAIL multi_dm got=%b/%0d/%0h/%0h/%0h exp=1/4/3004/deadbeef/90000004", out_valid, out_kind, out_tag, out_data, out_instr); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL multi_done got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 0;
    for (int i = 0; i < 9; i++) begin
      push_gpr(i, 32'(32'h100 + i), 32'(32'hA000_0000 + i));
      step();
    end
    clear_inputs();
    checks++; if ({drop_cnt, overflow} !== {16'd1, 1'b1}) begin failures++; $display("FAIL ovf_drop got=%0d/%b exp=1/1", drop_cnt, overflow); end
    checks++; if ({out_valid, out_tag} !== {1'b1, 32'd0}) begin failures++; $display("FAIL ovf_hold got=%b/%0h exp=1/0", out_valid, out_tag); end
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++; if ({out_valid, out_tag, out_data, out_instr} !== {1'b1, 32'(i), 32'(32'h100 + i), 32'(32'hA000_0000 + i)})
        begin failures++; $display("FAIL ovf_drain%0d got=%b/%0h/%0h/%0h exp=1/%0h/%0h/%0h", i, out_valid, out_tag, out_data, out_instr, i, 32'h100 + i, 32'hA000_0000 + i); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_full_pop_push();
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      push_gpr(16 + i, 32'(32'h200 + i), 32'h1234_0000);
      step();
    end
    clear_inputs();
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL full_fill_drop got=%0d exp=1", drop_cnt); end
    out_ready = 1;
    push_gpr(24, 32'h208, 32'h1234_0000);
    step();
    clear_inputs();
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL full_pop_drop got=%0d exp=1", drop_cnt); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if ({out_valid, out_tag, out_data} !== {1'b1, 32'(16 + i), 32'(32'h200 + i)})
        begin failures++; $display("FAIL full_drain%0d got=%b/%0h/%0h exp=1/%0h/%0h", i, out_valid, out_tag, out_data, 16 + i, 32'h200 + i); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      push_gpr(i, 32'(32'h300 + i), 32'h5555_0000);
      step();
    end
    clear_inputs();
    out_ready = 1;
    step();
    checks++; if ({out_valid, out_tag} !== {1'b1, 32'd1}) begin failures++; $display("FAIL mid_pre got=%b/%0h exp=1/1", out_valid, out_tag); end
    #3 rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
    checks++; if ({drop_cnt, overflow, out_tag} !== 49'd0) begin failures++; $display("FAIL mid_async_regs got=%0d/%b/%0h exp=0/0/0", drop_cnt, overflow, out_tag); end
    #1 rst_n = 1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_discard got=%b exp=0", out_valid); end
    // Post-reset bundle: MSR plus both SPR ports to the same index.
    msr_wr = 1; msr_wd = 32'h8000_0002; instr_w = 32'h7C00_03A6;
    spr_wr0 = 1; spr_waddr0 = 10'h1A0; spr_wd0 = 32'h1111_0000;
    spr_wr1 = 1; spr_waddr1 = 10'h1A0; spr_wd1 = 32'h2222_0000;
    step();
    clear_inputs();
    checks++; if ({out_valid, out_kind, out_tag, out_data} !== {1'b1, 3'd2, 32'd0, 32'h8000_0002})
      begin failures++; $display("FAIL post_msr got=%b/%0d/%0h/%0h exp=1/2/0/80000002", out_valid, out_kind, out_tag, out_data); end
    step();
    checks++; if ({out_valid, out_kind, out_tag, out_data, out_instr} !== {1'b1, 3'd3, 32'h1A0, 32'h1111_0000, 32'h7C00_03A6})
      begin failures++; $display("FAIL post_spr0 got=%b/%0d/%0h/%0h/%0h exp=1/3/1a0/11110000/7c0003a6", out_valid, out_kind, out_tag, out_data, out_instr); end
    step();
    checks++; if ({out_valid, out_kind, out_tag, out_data} !== {1'b1, 3'd3, 32'h1A0, 32'h2222_0000})
      begin failures++; $display("FAIL post_spr1 got=%b/%0d/%0h/%0h exp=1/3/1a0/22220000", out_valid, out_kind, out_tag, out_data); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_done got=%b exp=0", out_valid); end
  endtask

`ifdef COMMIT_TRACE_STALL_EN
  task automatic test_stall();
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      push_gpr(i, 32'(i), 32'h6666_0000);
      step();
    end
    clear_inputs();
    checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL stall_early got=%b exp=0", core_stall); end
    step();
    checks++; if (core_stall !== 1'b1) begin failures++; $display("FAIL stall_rise got=%b exp=1", core_stall); end
    checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL stall_drop got=%0d exp=0", drop_cnt); end
    out_ready = 1;
    repeat (8) step();
    checks++; if ({out_valid, core_stall} !== 2'b00) begin failures++; $display("FAIL stall_drain got=%b/%b exp=0/0", out_valid, core_stall); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_gpr();
    test_multi_event();
    test_overflow();
    test_full_pop_push();
    test_reset_mid_drain();
`ifdef COMMIT_TRACE_STALL_EN
    test_stall();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
